tp_sram: RTL and testbench

TP_SRAM -- requirements
Module: tp_sram

---
 rtl/tp_sram.sv | 162 ++++++++++++++++
 tb/tb_tp_sram.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_sram.sv
`default_nettype none
// ============================================================================
//  Module   : tp_sram
//  Purpose  : Two-port (one read, one write) synchronous SRAM with byte
//             enables, registered read data, a configurable same-address
//             collision policy and an optional zero-fill after reset.
//  Ports    : CLK      - clock, all state changes on the rising edge
//             RSTN     - asynchronous active-low reset
//             R_CSN    - read select (active-low)
//             R_ADDR   - read address
//             R_DOUT   - registered read data
//             R_VALID  - R_DOUT was updated on the last edge
//             W_CSN    - write select (active-low)
//             W_ADDR   - write address
//             W_BE     - byte enables, bit i covers W_DI[8i+7:8i]
//             W_DI     - write data
//             BUSY     - zero-fill in progress, both ports ignored
//  Revision : 1.0 - initial release
// ============================================================================
module tp_sram #(
  parameter int    DWIDTH     = 32,
  parameter int    AWIDTH     = 12,
  parameter int    SIZE       = 4096,
  parameter string ROMDATA    = "",
  parameter bit    INIT_CLEAR = 1'b0,
  parameter bit    BYPASS     = 1'b1
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                R_CSN,
  input  logic [AWIDTH-1:0]   R_ADDR,
  output logic [DWIDTH-1:0]   R_DOUT,
  output logic                R_VALID,
  input  logic                W_CSN,
  input  logic [AWIDTH-1:0]   W_ADDR,
  input  logic [DWIDTH/8-1:0] W_BE,
  input  logic [DWIDTH-1:0]   W_DI,
  output logic                BUSY
);

  localparam int NBYTES = DWIDTH / 8;
  // Index width that exactly matches the array depth.
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AWIDTH:0]   SIZE_W    = (AWIDTH + 1)'(SIZE);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(SIZE - 1);

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;

  logic [DWIDTH-1:0] mem [0:SIZE-1];

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic [DWIDTH-1:0]   r_dout_q, r_dout_d;
  logic                r_valid_q, r_valid_d;

  logic                rd_in_range;
  logic                wr_in_range;
  logic                rd_en;
  logic                wr_en;
  logic                collide;
  logic [DWIDTH-1:0]   rd_word;
  logic [DWIDTH-1:0]   merged_word;

  logic                mem_we;
  logic [IW-1:0]       mem_addr;
  logic [NBYTES-1:0]   mem_be;
  logic [DWIDTH-1:0]   mem_data;

  always_comb begin
    rd_in_range = ({1'b0, R_ADDR} < SIZE_W);
    wr_in_range = ({1'b0, W_ADDR} < SIZE_W);
    rd_en       = (state_q == ST_READY) && !R_CSN;
    // Out-of-range writes are dropped here so they can never alias.
    wr_en       = (state_q == ST_READY) && !W_CSN && wr_in_range;
    collide     = wr_en && (W_ADDR == R_ADDR);

    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[R_ADDR[IW-1:0]];
    end

    // Old word with the enabled bytes of the incoming write applied.
    merged_word = rd_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (W_BE[i]) begin
        merged_word[8*i +: 8] = W_DI[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_dout_d  = r_dout_q;
    r_valid_d = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = W_ADDR[IW-1:0];
    mem_be    = W_BE;
    mem_data  = W_DI;

    case (state_q)
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt_q[IW-1:0];
        mem_be   = '1;
        mem_data = '0;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (rd_en) begin
          r_valid_d = 1'b1;
          r_dout_d  = (BYPASS && collide) ? merged_word : rd_word;
        end
        mem_we = wr_en;
      end
    endcase

    // An edge that lands while reset is held must not disturb the array.
    mem_we = mem_we && RSTN;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      r_dout_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_dout_q  <= r_dout_d;
      r_valid_q <= r_valid_d;
    end
  end

  // Array has no reset so its contents survive RSTN.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
        end
      end
    end
  end

  assign R_DOUT  = r_dout_q;
  assign R_VALID = r_valid_q;
  assign BUSY    = (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_tp_sram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tp_sram
//  Purpose  : Self-checking bench for tp_sram. Five instances cover the
//             write-first / read-first defaults, the zero-fill variant,
//             out-of-range addressing and a 64-bit data width.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tp_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t mk(input string name, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.name  = name;
    e.exp_a = a;
    e.exp_b = b;
    return e;
  endfunction

  // Group A: shared stimulus into write-first (d_) and read-first (f_) copies
  logic        a_rstn = 1'b0;
  logic        a_rcsn = 1'b1;
  logic [11:0] a_raddr = '0;
  logic        a_wcsn = 1'b1;
  logic [11:0] a_waddr = '0;
  logic [3:0]  a_wbe = '0;
  logic [31:0] a_wdi = '0;
  logic [31:0] d_dout, f_dout;
  logic        d_valid, f_valid, d_busy, f_busy;

  tp_sram #(.BYPASS(1'b1)) u_dflt (
    .CLK(clk), .RSTN(a_rstn), .R_CSN(a_rcsn), .R_ADDR(a_raddr), .R_DOUT(d_dout),
    .R_VALID(d_valid), .W_CSN(a_wcsn), .W_ADDR(a_waddr), .W_BE(a_wbe), .W_DI(a_wdi),
    .BUSY(d_busy));

  tp_sram #(.BYPASS(1'b0)) u_rfirst (
    .CLK(clk), .RSTN(a_rstn), .R_CSN(a_rcsn), .R_ADDR(a_raddr), .R_DOUT(f_dout),
    .R_VALID(f_valid), .W_CSN(a_wcsn), .W_ADDR(a_waddr), .W_BE(a_wbe), .W_DI(a_wdi),
    .BUSY(f_busy));

  // Group C: zero-fill after reset, 16 words
  logic        c_rstn = 1'b0;
  logic        c_rcsn = 1'b1;
  logic [3:0]  c_raddr = '0;
  logic        c_wcsn = 1'b1;
  logic [3:0]  c_waddr = '0;
  logic [3:0]  c_wbe = '0;
  logic [31:0] c_wdi = '0;
  logic [31:0] c_dout;
  logic        c_valid, c_busy;

  tp_sram #(.AWIDTH(4), .SIZE(16), .INIT_CLEAR(1'b1)) u_clr (
    .CLK(clk), .RSTN(c_rstn), .R_CSN(c_rcsn), .R_ADDR(c_raddr), .R_DOUT(c_dout),
    .R_VALID(c_valid), .W_CSN(c_wcsn), .W_ADDR(c_waddr), .W_BE(c_wbe), .W_DI(c_wdi),
    .BUSY(c_busy));

  // Group OB: 16 words behind a 5-bit address
  logic        ob_rcsn = 1'b1;
  logic [4:0]  ob_raddr = '0;
  logic        ob_wcsn = 1'b1;
  logic [4:0]  ob_waddr = '0;
  logic [3:0]  ob_wbe = '0;
  logic [31:0] ob_wdi = '0;
  logic [31:0] ob_dout;
  logic        ob_valid, ob_busy;

  tp_sram #(.AWIDTH(5), .SIZE(16)) u_oob (
    .CLK(clk), .RSTN(a_rstn), .R_CSN(ob_rcsn), .R_ADDR(ob_raddr), .R_DOUT(ob_dout),
    .R_VALID(ob_valid), .W_CSN(ob_wcsn), .W_ADDR(ob_waddr), .W_BE(ob_wbe), .W_DI(ob_wdi),
    .BUSY(ob_busy));

  // Group WD: 64-bit data
  logic        wd_rcsn = 1'b1;
  logic [3:0]  wd_raddr = '0;
  logic        wd_wcsn = 1'b1;
  logic [3:0]  wd_waddr = '0;
  logic [7:0]  wd_wbe = '0;
  logic [63:0] wd_wdi = '0;
  logic [63:0] wd_dout;
  logic        wd_valid, wd_busy;

  tp_sram #(.DWIDTH(64), .AWIDTH(4), .SIZE(16)) u_wide (
    .CLK(clk), .RSTN(a_rstn), .R_CSN(wd_rcsn), .R_ADDR(wd_raddr), .R_DOUT(wd_dout),
    .R_VALID(wd_valid), .W_CSN(wd_wcsn), .W_ADDR(wd_waddr), .W_BE(wd_wbe), .W_DI(wd_wdi),
    .BUSY(wd_busy));

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic rcsn, input logic [11:0] raddr, input logic wcsn,
                         input logic [11:0] waddr, input logic [3:0] wbe, input logic [31:0] wdi);
    a_rcsn = rcsn; a_raddr = raddr; a_wcsn = wcsn; a_waddr = waddr; a_wbe = wbe; a_wdi = wdi;
    tick();
    a_rcsn = 1'b1; a_wcsn = 1'b1;
  endtask

  task automatic c_drive(input logic rcsn, input logic [3:0] raddr, input logic wcsn,
                         input logic [3:0] waddr, input logic [3:0] wbe, input logic [31:0] wdi);
    c_rcsn = rcsn; c_raddr = raddr; c_wcsn = wcsn; c_waddr = waddr; c_wbe = wbe; c_wdi = wdi;
    tick();
    c_rcsn = 1'b1; c_wcsn = 1'b1;
  endtask

  task automatic ob_drive(input logic rcsn, input logic [4:0] raddr, input logic wcsn,
                          input logic [4:0] waddr, input logic [3:0] wbe, input logic [31:0] wdi);
    ob_rcsn = rcsn; ob_raddr = raddr; ob_wcsn = wcsn; ob_waddr = waddr; ob_wbe = wbe; ob_wdi = wdi;
    tick();
    ob_rcsn = 1'b1; ob_wcsn = 1'b1;
  endtask

  task automatic wd_drive(input logic rcsn, input logic [3:0] raddr, input logic wcsn,
                          input logic [3:0] waddr, input logic [7:0] wbe, input logic [63:0] wdi);
    wd_rcsn = rcsn; wd_raddr = raddr; wd_wcsn = wcsn; wd_waddr = waddr; wd_wbe = wbe; wd_wdi = wdi;
    tick();
    wd_rcsn = 1'b1; wd_wcsn = 1'b1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    tick();
    tests++;
    if (d_dout !== 32'h0 || d_valid !== 1'b0 || d_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_dflt: dout=%h valid=%b busy=%b, expected 0/0/0", d_dout, d_valid, d_busy);
    end
    tests++;
    if (f_dout !== 32'h0 || f_valid !== 1'b0 || f_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_rfirst: dout=%h valid=%b busy=%b, expected 0/0/0", f_dout, f_valid, f_busy);
    end
    tests++;
    if (c_dout !== 32'h0 || c_valid !== 1'b0 || c_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_clr: dout=%h valid=%b busy=%b, expected 0/0/1", c_dout, c_valid, c_busy);
    end
    tests++;
    if (ob_valid !== 1'b0 || ob_busy !== 1'b0 || wd_valid !== 1'b0 || wd_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_misc: ob valid/busy=%b%b wd valid/busy=%b%b, expected 0000",
               ob_valid, ob_busy, wd_valid, wd_busy);
    end
    a_rstn = 1'b1;
    tick();
  endtask

  task automatic test_byte_enable();
    exp_t e;
    a_drive(1'b1, 12'd0, 1'b0, 12'd5, 4'hF, 32'hDEADBEEF);
    a_drive(1'b1, 12'd0, 1'b0, 12'd5, 4'b0010, 32'h0000AA00);
    sbq.push_back(mk("be_merge", 64'hDEADAAEF, 64'hDEADAAEF));
    a_drive(1'b0, 12'd5, 1'b1, 12'd0, 4'h0, 32'h0);
    e = sbq.pop_front();
    tests++;
    if (d_dout !== e.exp_a[31:0] || d_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_wf: dout=%h valid=%b, expected %h valid=1", e.name, d_dout, d_valid, e.exp_a[31:0]);
    end
    tests++;
    if (f_dout !== e.exp_b[31:0] || f_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_rf: dout=%h valid=%b, expected %h valid=1", e.name, f_dout, f_valid, e.exp_b[31:0]);
    end
    // Idle edge: valid drops, data holds.
    a_drive(1'b1, 12'd0, 1'b1, 12'd0, 4'h0, 32'h0);
    tests++;
    if (d_dout !== 32'hDEADAAEF || d_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_idle: dout=%h valid=%b, expected DEADAAEF valid=0", d_dout, d_valid);
    end
    // All byte enables low must leave the word untouched.
    a_drive(1'b1, 12'd0, 1'b0, 12'd5, 4'h0, 32'hFFFFFFFF);
    sbq.push_back(mk("be_zero", 64'hDEADAAEF, 64'hDEADAAEF));
    a_drive(1'b0, 12'd5, 1'b1, 12'd0, 4'h0, 32'h0);
    e = sbq.pop_front();
    tests++;
    if (d_dout !== e.exp_a[31:0] || d_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, d_dout, d_valid, e.exp_a[31:0]);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    logic [31:0] wdi [3];
    logic [3:0]  wbe [3];
    logic        wcs [3];
    wdi = '{32'h22222222, 32'h0, 32'h000000AB};
    wbe = '{4'hF, 4'h0, 4'b0001};
    wcs = '{1'b0, 1'b1, 1'b0};
    a_drive(1'b1, 12'd0, 1'b0, 12'd7, 4'hF, 32'h11111111);
    sbq.push_back(mk("collide_full", 64'h22222222, 64'h11111111));
    sbq.push_back(mk("after_collide", 64'h22222222, 64'h22222222));
    sbq.push_back(mk("collide_byte", 64'h222222AB, 64'h22222222));
    for (int i = 0; i < 3; i++) begin
      a_drive(1'b0, 12'd7, wcs[i], 12'd7, wbe[i], wdi[i]);
      e = sbq.pop_front();
      tests++;
      if (d_dout !== e.exp_a[31:0] || d_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s_wf: dout=%h valid=%b, expected %h valid=1", e.name, d_dout, d_valid, e.exp_a[31:0]);
      end
      tests++;
      if (f_dout !== e.exp_b[31:0] || f_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s_rf: dout=%h valid=%b, expected %h valid=1", e.name, f_dout, f_valid, e.exp_b[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [11:0] ra [4];
    logic [31:0] ex [4];
    a_drive(1'b1, 12'd0, 1'b0, 12'd100, 4'hF, 32'hCAFEF00D);
    // Read 100 while writing 200, then stream reads with no gaps.
    ra = '{12'd100, 12'd200, 12'd5, 12'd7};
    ex = '{32'hCAFEF00D, 32'h0BADC0DE, 32'hDEADAAEF, 32'h222222AB};
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(mk($sformatf("b2b_%0d", i), {32'h0, ex[i]}, {32'h0, ex[i]}));
      if (i == 0) a_drive(1'b0, ra[i], 1'b0, 12'd200, 4'hF, 32'h0BADC0DE);
      else        a_drive(1'b0, ra[i], 1'b1, 12'd0, 4'h0, 32'h0);
      e = sbq.pop_front();
      tests++;
      if (d_dout !== e.exp_a[31:0] || d_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, d_dout, d_valid, e.exp_a[31:0]);
      end
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    logic [4:0]  ra [3];
    logic [31:0] ex [3];
    ob_drive(1'b1, 5'd0, 1'b0, 5'd4, 4'hF, 32'h12345678);
    ob_drive(1'b1, 5'd0, 1'b0, 5'd20, 4'hF, 32'hFFFFFFFF);
    ra = '{5'd4, 5'd20, 5'd4};
    ex = '{32'h12345678, 32'h0, 32'h12345678};
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(mk($sformatf("oob_rd_%0d", ra[i]), {32'h0, ex[i]}, 64'h0));
      ob_drive(1'b0, ra[i], 1'b1, 5'd0, 4'h0, 32'h0);
      e = sbq.pop_front();
      tests++;
      if (ob_dout !== e.exp_a[31:0] || ob_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, ob_dout, ob_valid, e.exp_a[31:0]);
      end
    end
  endtask

  task automatic test_wide();
    exp_t e;
    wd_drive(1'b1, 4'd0, 1'b0, 4'd2, 8'hFF, 64'h0);
    wd_drive(1'b1, 4'd0, 1'b0, 4'd2, 8'h80, 64'h5AFFFFFFFFFFFFFF);
    sbq.push_back(mk("wide_top", 64'h5A00000000000000, 64'h0));
    wd_drive(1'b0, 4'd2, 1'b1, 4'd0, 8'h0, 64'h0);
    e = sbq.pop_front();
    tests++;
    if (wd_dout !== e.exp_a || wd_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, wd_dout, wd_valid, e.exp_a);
    end
    wd_drive(1'b1, 4'd0, 1'b0, 4'd2, 8'h01, 64'hFFFFFFFFFFFFFF77);
    sbq.push_back(mk("wide_low", 64'h5A00000000000077, 64'h0));
    wd_drive(1'b0, 4'd2, 1'b1, 4'd0, 8'h0, 64'h0);
    e = sbq.pop_front();
    tests++;
    if (wd_dout !== e.exp_a || wd_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, wd_dout, wd_valid, e.exp_a);
    end
  endtask

  task automatic test_reset_retention();
    exp_t e;
    a_drive(1'b1, 12'd0, 1'b0, 12'd9, 4'hF, 32'h13572468);
    sbq.push_back(mk("pre_rst", 64'hDEADAAEF, 64'hDEADAAEF));
    a_drive(1'b0, 12'd5, 1'b1, 12'd0, 4'h0, 32'h0);
    e = sbq.pop_front();
    tests++;
    if (d_dout !== e.exp_a[31:0] || d_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, d_dout, d_valid, e.exp_a[31:0]);
    end
    // Write to addr 9 held across an edge that sees reset low.
    a_rcsn = 1'b0; a_raddr = 12'd5;
    a_wcsn = 1'b0; a_waddr = 12'd9; a_wbe = 4'hF; a_wdi = 32'hFFFFFFFF;
    #1 a_rstn = 1'b0;
    #1;
    tests++;
    if (d_dout !== 32'h0 || d_valid !== 1'b0 || f_dout !== 32'h0 || f_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_a: dout=%h/%h valid=%b/%b, expected 0/0", d_dout, f_dout, d_valid, f_valid);
    end
    tick();
    a_wcsn = 1'b1; a_rcsn = 1'b1;
    a_rstn = 1'b1;
    sbq.push_back(mk("retain_9", 64'h13572468, 64'h13572468));
    sbq.push_back(mk("retain_5", 64'hDEADAAEF, 64'hDEADAAEF));
    for (int i = 0; i < 2; i++) begin
      a_drive(1'b0, (i == 0) ? 12'd9 : 12'd5, 1'b1, 12'd0, 4'h0, 32'h0);
      e = sbq.pop_front();
      tests++;
      if (d_dout !== e.exp_a[31:0] || d_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s_wf: dout=%h valid=%b, expected %h valid=1", e.name, d_dout, d_valid, e.exp_a[31:0]);
      end
      tests++;
      if (f_dout !== e.exp_b[31:0] || f_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s_rf: dout=%h valid=%b, expected %h valid=1", e.name, f_dout, f_valid, e.exp_b[31:0]);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int busy_cycles;
    c_rcsn = 1'b0; c_raddr = 4'd3;
    c_wcsn = 1'b0; c_waddr = 4'd3; c_wbe = 4'hF; c_wdi = 32'hFFFFFFFF;
    c_rstn = 1'b1;
    busy_cycles = (c_busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      tests++;
      if (c_valid !== 1'b0 || c_busy !== (k < 16)) begin
        fails++;
        $display("FAIL clear_cyc_%0d: valid=%b busy=%b, expected valid=0 busy=%b", k, c_valid, c_busy, (k < 16));
      end
      if (c_busy === 1'b1) busy_cycles++;
    end
    c_rcsn = 1'b1; c_wcsn = 1'b1;
    tests++;
    if (busy_cycles != 16) begin
      fails++;
      $display("FAIL clear_len: busy for %0d cycles, expected 16", busy_cycles);
    end
    for (int a = 0; a < 16; a++) begin
      sbq.push_back(mk($sformatf("clear_rd_%0d", a), 64'h0, 64'h0));
      c_drive(1'b0, a[3:0], 1'b1, 4'd0, 4'h0, 32'h0);
      e = sbq.pop_front();
      tests++;
      if (c_dout !== e.exp_a[31:0] || c_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, c_dout, c_valid, e.exp_a[31:0]);
      end
    end
  endtask

  task automatic test_clear_restart();
    exp_t e;
    for (int a = 0; a < 16; a++) c_drive(1'b1, 4'd0, 1'b0, a[3:0], 4'hF, 32'hFFFFFFFF);
    sbq.push_back(mk("fill_ones", 64'hFFFFFFFF, 64'h0));
    c_drive(1'b0, 4'd11, 1'b1, 4'd0, 4'h0, 32'h0);
    e = sbq.pop_front();
    tests++;
    if (c_dout !== e.exp_a[31:0] || c_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, c_dout, c_valid, e.exp_a[31:0]);
    end
    for (int p = 0; p < 2; p++) begin
      #1 c_rstn = 1'b0;
      #1;
      tests++;
      if (c_dout !== 32'h0 || c_valid !== 1'b0 || c_busy !== 1'b1) begin
        fails++;
        $display("FAIL async_rst_c%0d: dout=%h valid=%b busy=%b, expected 0/0/1", p, c_dout, c_valid, c_busy);
      end
      #2 c_rstn = 1'b1;
      // First pass stops at clear cycle 8; second pass must run the full 16.
      for (int k = 1; k <= ((p == 0) ? 8 : 16); k++) begin
        tick();
        tests++;
        if (c_busy !== (k < 16)) begin
          fails++;
          $display("FAIL restart_p%0d_cyc_%0d: busy=%b, expected %b", p, k, c_busy, (k < 16));
        end
      end
    end
    for (int a = 0; a < 16; a++) begin
      sbq.push_back(mk($sformatf("restart_rd_%0d", a), 64'h0, 64'h0));
      c_drive(1'b0, a[3:0], 1'b1, 4'd0, 4'h0, 32'h0);
      e = sbq.pop_front();
      tests++;
      if (c_dout !== e.exp_a[31:0] || c_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s: dout=%h valid=%b, expected %h valid=1", e.name, c_dout, c_valid, e.exp_a[31:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_wide();
    test_reset_retention();
    test_clear();
    test_clear_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
